mux_nx1_rr: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes: fixed select (software-driven `sel`, the classic mux behaviour) and round-robin arbitration across valid channels.
- A single output register stage gives one-cycle latency and full throughput.
- Sits between multiple producer blocks and one shared consumer.

---
 rtl/mux_nx1_rr.sv | 124 ++++++++++++
 tb/tb_mux_nx1_rr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-channel registered multiplexer with valid/ready handshakes.
// mode=0 passes the channel chosen by sel. mode=1 arbitrates round-robin
// across the valid channels. One output register stage gives one-cycle
// latency and full throughput. When the register drains and reloads on the
// same edge, no bubble is inserted.
module mux_nx1_rr #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_r;
    logic                out_valid_r;
    logic [SEL_W-1:0]    out_chan_r;
    logic [SEL_W-1:0]    last_grant_r;

    logic                load_en_s;
    logic                grant_vld_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic [CHANNELS-1:0] grant_oh_s;
    logic [WIDTH-1:0]    grant_data_s;

    // The register can take a new word when it is empty or its word leaves this edge.
    assign load_en_s = ~out_valid_r | out_ready;

    // Pick the granted channel.
    // In fixed mode, a sel value outside the channel range matches no channel.
    // In round-robin mode, the search starts one channel after the last grant.
    always_comb begin
        logic [SEL_W-1:0] cand_v;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_v      = '0;
        if (mode == 1'b0) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if ((sel == SEL_W'(k)) && in_valid[k]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = SEL_W'(k);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            for (int off = 1; off <= CHANNELS; off++) begin
                cand_v = SEL_W'((int'(last_grant_r) + off) % CHANNELS);
                if (!grant_vld_s && in_valid[cand_v]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_v;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
    end

    // Expand the grant into a one-hot vector and select the granted data word.
    always_comb begin
        grant_oh_s   = '0;
        grant_data_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_vld_s && (grant_idx_s == SEL_W'(k))) begin
                grant_oh_s[k] = 1'b1;
                grant_data_s  = in_data[k*WIDTH +: WIDTH];
            end else begin
                grant_oh_s[k] = 1'b0;
            end
        end
    end

    // Ready goes only to the granted channel, and only while the register can load.
    // Ready does not depend on the data path.
    always_comb begin
        if (load_en_s) begin
            in_ready = grant_oh_s;
        end else begin
            in_ready = '0;
        end
    end

    // Output register and round-robin pointer.
    // The pointer starts at the last channel, so the first search begins at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r   <= '0;
            out_valid_r  <= 1'b0;
            out_chan_r   <= '0;
            last_grant_r <= SEL_W'(CHANNELS - 1);
        end else if (load_en_s) begin
            if (grant_vld_s) begin
                out_data_r  <= grant_data_s;
                out_chan_r  <= grant_idx_s;
                out_valid_r <= 1'b1;
                if (mode == 1'b1) begin
                    last_grant_r <= grant_idx_s;
                end else begin
                    last_grant_r <= last_grant_r;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_data_r  <= out_data_r;
            out_valid_r <= out_valid_r;
            out_chan_r  <= out_chan_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb_mux_nx1_rr: directed scoreboard bench for mux_nx1_rr (WIDTH=8, CHANNELS=4).
// The driver pushes the hand-computed {chan,data} expected for each transfer
// it sets up. The monitor pops and compares on every output handshake.
module tb_mux_nx1_rr;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic        out_ready;

    int          tests_run;
    int          tests_failed;
    logic [9:0]  exp_q[$];

    mux_nx1_rr #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = r;
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_output: got chan=%0d data=0x%0h, expected none", out_chan, out_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_chan", {30'd0, out_chan}, {30'd0, e[9:8]});
                chk("sb_data", {24'd0, out_data}, {24'd0, e[7:0]});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_data      = {8'h13, 8'hC3, 8'h11, 8'h10};
        drive(1'b0, 2'd0, 4'b0000, 1'b0);
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_chan", {30'd0, out_chan}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fixed select: channel 2 is selected and valid.
        drive(1'b0, 2'd2, 4'b0100, 1'b1);
        #1;
        chk("fix_in_ready", {28'd0, in_ready}, {28'd0, 4'b0100});
        exp_q.push_back({2'd2, 8'hC3});
        tick();
        chk("fix_out_valid", {31'd0, out_valid}, 32'd1);

        // Fixed select: the selected channel is idle, so nothing is granted.
        drive(1'b0, 2'd1, 4'b1101, 1'b1);
        #1;
        chk("fix_nogrant_ready", {28'd0, in_ready}, 32'd0);
        tick();
        chk("fix_nogrant_valid", {31'd0, out_valid}, 32'd0);

        // Round robin: all channels valid, back-to-back grants 0,1,2,3,0.
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_in_ready", {28'd0, in_ready}, 32'd1 << (i % 4));
            exp_q.push_back({2'(i % 4), 8'h10 + 8'(i % 4)});
            tick();
            chk("rr_no_bubble", {31'd0, out_valid}, 32'd1);
        end
        drive(1'b1, 2'd0, 4'b0000, 1'b1);
        tick();

        // Backpressure: a channel 0 word is held while out_ready is low.
        drive(1'b1, 2'd0, 4'b0001, 1'b1);
        #1;
        chk("bp_load_ready", {28'd0, in_ready}, 32'd1);
        exp_q.push_back({2'd0, 8'h10});
        tick();
        drive(1'b1, 2'd0, 4'b0110, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {28'd0, in_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", {24'd0, out_data}, 32'h10);
            chk("bp_hold_chan", {30'd0, out_chan}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, in_ready}, {28'd0, 4'b0010});
        exp_q.push_back({2'd1, 8'h11});
        tick();
        chk("bp_reload_chan", {30'd0, out_chan}, 32'd1);
        #1;
        chk("bp_next_ready", {28'd0, in_ready}, {28'd0, 4'b0100});
        exp_q.push_back({2'd2, 8'h12});
        tick();

        // Wrap-around skipping idle channels: 3, then 0, 3, 0.
        drive(1'b1, 2'd0, 4'b1000, 1'b1);
        #1;
        chk("wrap_ready_3", {28'd0, in_ready}, {28'd0, 4'b1000});
        exp_q.push_back({2'd3, 8'h13});
        tick();
        in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wrap_in_ready", {28'd0, in_ready}, (i % 2 == 0) ? 32'd1 : 32'd8);
            exp_q.push_back((i % 2 == 0) ? {2'd0, 8'h10} : {2'd3, 8'h13});
            tick();
        end
        in_valid = 4'b0000;
        tick();
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while a word sits in the register.
        drive(1'b1, 2'd0, 4'b0010, 1'b1);
        #1;
        chk("ar_load_ready", {28'd0, in_ready}, {28'd0, 4'b0010});
        tick();
        drive(1'b1, 2'd0, 4'b0000, 1'b0);
        #2;
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_out_data", {24'd0, out_data}, 32'd0);
        chk("ar_out_chan", {30'd0, out_chan}, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        #1;
        chk("ar_first_grant", {28'd0, in_ready}, 32'd1);
        exp_q.push_back({2'd0, 8'h10});
        tick();
        in_valid = 4'b0000;

        // Drain remaining expectations with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick();
        end
        chk("sb_drain", exp_q.size(), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
